// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the 5-stage pipeline sequencer:
//   - ctrl_state_e : sequencer state encoding (BOOT/RUN/FREEZE/HALT),
//                    also exported on the ctrl_state debug port
//   - REG_ZERO     : index of the hard-wired zero register (x0)
//   - control_*_t  : control-bit layout carried by the stage registers;
//                    a bubble is these fields forced to zero
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    FREEZE = 2'd2,
    HALT   = 2'd3
  } ctrl_state_e;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } control_wb_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
  } control_mem_t;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
  } control_ex_t;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// hazard_detect
// Purely combinational load-use compare between the instruction in IF/ID
// and a load sitting in ID/EX.
//   id_rs1, id_rs2           : source registers of the IF/ID instruction
//   id_uses_rs1, id_uses_rs2 : whether each source is actually read
//   ex_rd, ex_mem_read       : destination of ID/EX and whether it is a load
//   load_use                 : 1 when the IF/ID instruction must wait a cycle
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  output logic              load_use
);

  logic [REG_AW-1:0] zero_reg;
  logic              rs1_hit;
  logic              rs2_hit;

  assign zero_reg = REG_AW'(REG_ZERO);

  // A load targeting x0 writes nothing, so it can never feed a dependent.
  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_mem_read && (ex_rd != zero_reg) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Pipeline sequencer for the 5-stage core. Drives PC write enable, per-stage
// register enables and bubble (flush) controls. Priority each RUN/FREEZE
// cycle: data-memory freeze, taken-branch squash, load-use stall. Also runs a
// post-reset boot drain and a data-memory watchdog that halts on a hung access.
// Ports:
//   clk, res (async, active-high)
//   id_rs1/id_rs2/id_uses_rs1/id_uses_rs2/ex_rd/ex_mem_read : hazard inputs
//   mem_pcsrc  : branch in EX/MEM resolved taken
//   dmem_busy  : data memory not ready this cycle
//   pc_we, ifid_we, idex_we, exmem_we, memwb_we : enables
//   ifid_flush, idex_flush, exmem_flush         : bubble controls
//   wdt_err    : sticky watchdog error
//   ctrl_state : current state (debug)
// Optional feature macro HAZARD_PERF_EN adds 32-bit stall_cnt, flush_cnt and
// freeze_cnt performance counters (absent in the default build).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 4,
  parameter int WDT_LIMIT   = 64,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              res,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              mem_pcsrc,
  input  logic              dmem_busy,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idex_we,
  output logic              exmem_we,
  output logic              memwb_we,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic              wdt_err,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
  output logic [31:0]       freeze_cnt,
`endif
  output logic [1:0]        ctrl_state
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WDT_W  = $clog2(WDT_LIMIT);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [WDT_W-1:0]  WDT_LAST  = WDT_W'(WDT_LIMIT - 1);

  ctrl_state_e       state_q, state_d;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [WDT_W-1:0]  wdt_cnt_q, wdt_cnt_d;
  logic              wdt_err_q, wdt_err_d;
  logic              load_use;
  logic              in_chain;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign in_chain   = (state_q == RUN) || (state_q == FREEZE);
  assign wdt_err    = wdt_err_q;
  assign ctrl_state = state_q;

  // Next state, boot drain and watchdog. The watchdog only advances while
  // memory is busy, so any ready cycle both clears it and ends FREEZE.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    wdt_cnt_d  = wdt_cnt_q;
    wdt_err_d  = wdt_err_q;
    case (state_q)
      BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = RUN;
          boot_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + BOOT_W'(1);
        end
      end
      RUN, FREEZE: begin
        if (dmem_busy) begin
          if (wdt_cnt_q == WDT_LAST) begin
            state_d   = HALT;
            wdt_err_d = 1'b1;
          end else begin
            state_d   = FREEZE;
            wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
          end
        end else begin
          state_d   = RUN;
          wdt_cnt_d = '0;
        end
      end
      HALT: begin
        state_d = HALT;
      end
    endcase
  end

  // Zero-latency control outputs from state and the priority chain.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    case (state_q)
      BOOT: begin
        // Drain: clock bubbles through every stage while the PC holds.
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end
      RUN, FREEZE: begin
        if (dmem_busy) begin
          pc_we = 1'b0;
        end else if (mem_pcsrc) begin
          // Squash everything younger than the branch; a load-use hazard
          // on a squashed instruction does not matter.
          pc_we       = 1'b1;
          ifid_we     = 1'b1;
          idex_we     = 1'b1;
          exmem_we    = 1'b1;
          memwb_we    = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF/ID, insert one bubble behind the load.
          idex_we    = 1'b1;
          exmem_we   = 1'b1;
          memwb_we   = 1'b1;
          idex_flush = 1'b1;
        end else begin
          pc_we    = 1'b1;
          ifid_we  = 1'b1;
          idex_we  = 1'b1;
          exmem_we = 1'b1;
          memwb_we = 1'b1;
        end
      end
      HALT: begin
        pc_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      wdt_cnt_q  <= '0;
      wdt_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      wdt_cnt_q  <= wdt_cnt_d;
      wdt_err_q  <= wdt_err_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] freeze_cnt_q, freeze_cnt_d;

  // Each counter follows exactly one rule of the priority chain.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (in_chain) begin
      if (dmem_busy) begin
        freeze_cnt_d = freeze_cnt_q + 32'd1;
      end else if (mem_pcsrc) begin
        flush_cnt_d = flush_cnt_q + 32'd1;
      end else if (load_use) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`else
  logic unused_in_chain;
  assign unused_in_chain = in_chain;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
// Directed self-checking bench for pipe_ctrl with BOOT_CYCLES=4, WDT_LIMIT=8.
// Inputs change 2 time units after each rising edge; outputs are compared a
// unit later, well away from the next edge. HAZARD_PERF_EN enables the
// performance-counter steps as well.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       res;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, mem_pcsrc, dmem_busy;
  logic       pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic       ifid_flush, idex_flush, exmem_flush, wdt_err;
  logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // 10-unit clock period.
  always #5 clk = ~clk;

  pipe_ctrl #(.BOOT_CYCLES(4), .WDT_LIMIT(8), .REG_AW(5)) dut (
    .clk         (clk),
    .res         (res),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .mem_pcsrc   (mem_pcsrc),
    .dmem_busy   (dmem_busy),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .idex_we     (idex_we),
    .exmem_we    (exmem_we),
    .memwb_we    (memwb_we),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .wdt_err     (wdt_err),
`ifdef HAZARD_PERF_EN
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .freeze_cnt  (freeze_cnt),
`endif
    .ctrl_state  (ctrl_state)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive one input vector, then let combinational outputs settle.
  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2,
                               input logic [4:0] rd, input logic mr,
                               input logic pcsrc, input logic busy);
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_uses_rs1 = u1;
    id_uses_rs2 = u2;
    ex_rd       = rd;
    ex_mem_read = mr;
    mem_pcsrc   = pcsrc;
    dmem_busy   = busy;
    #1;
  endtask

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  // Compare the full control vector: pc_we, four enables, three flushes.
  task automatic checkCtrl(input string tag, input logic [7:0] exp);
    checkOutput({tag, ".pc_we"},       32'(pc_we),       32'(exp[7]));
    checkOutput({tag, ".ifid_we"},     32'(ifid_we),     32'(exp[6]));
    checkOutput({tag, ".idex_we"},     32'(idex_we),     32'(exp[5]));
    checkOutput({tag, ".exmem_we"},    32'(exmem_we),    32'(exp[4]));
    checkOutput({tag, ".memwb_we"},    32'(memwb_we),    32'(exp[3]));
    checkOutput({tag, ".ifid_flush"},  32'(ifid_flush),  32'(exp[2]));
    checkOutput({tag, ".idex_flush"},  32'(idex_flush),  32'(exp[1]));
    checkOutput({tag, ".exmem_flush"}, 32'(exmem_flush), 32'(exp[0]));
  endtask

  // Control vectors {pc, ifid, idex, exmem, memwb, fl_if, fl_id, fl_ex}.
  localparam logic [7:0] V_BOOT   = 8'b0_1111_111;
  localparam logic [7:0] V_NORMAL = 8'b1_1111_000;
  localparam logic [7:0] V_STALL  = 8'b0_0111_010;
  localparam logic [7:0] V_BRANCH = 8'b1_1111_111;
  localparam logic [7:0] V_IDLE   = 8'b0_0000_000;

  initial begin
    res = 1'b1;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // Reset state.
    checkCtrl("reset", V_BOOT);
    checkOutput("reset.state", 32'(ctrl_state), 32'd0);
    checkOutput("reset.wdt_err", 32'(wdt_err), 32'd0);

    // Boot drain ignores dmem_busy and lasts exactly 4 edges.
    res = 1'b0;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkCtrl($sformatf("boot%0d", i), V_BOOT);
      checkOutput($sformatf("boot%0d.state", i), 32'(ctrl_state), 32'd0);
      tick();
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkCtrl("run_first", V_NORMAL);
    checkOutput("run_first.state", 32'(ctrl_state), 32'd1);
    tick();

    // Load-use on rs2, lasting one cycle.
    applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    checkCtrl("lu_rs2", V_STALL);
    tick();
    applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checkCtrl("lu_rs2_after", V_NORMAL);
    tick();

    // x0 destination never stalls.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    checkCtrl("lu_x0", V_NORMAL);
    // rs1 hazard, and the same registers with rs1 not read.
    applyStimulus(5'd7, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    checkCtrl("lu_rs1", V_STALL);
    applyStimulus(5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    checkCtrl("lu_rs1_unused", V_NORMAL);
    // Non-load producer: no stall.
    applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    checkCtrl("no_load", V_NORMAL);

    // Branch wins over a simultaneous load-use.
    applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    checkCtrl("branch_lu", V_BRANCH);
    tick();

    // Freeze with a pending branch for 3 cycles, then the flush applies.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkCtrl($sformatf("freeze%0d", i), V_IDLE);
      checkOutput($sformatf("freeze%0d.state", i), 32'(ctrl_state),
                  (i == 0) ? 32'd1 : 32'd2);
      tick();
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    checkCtrl("freeze_exit", V_BRANCH);
    checkOutput("freeze_exit.state", 32'(ctrl_state), 32'd2);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("freeze_back.state", 32'(ctrl_state), 32'd1);

    // Seven busy cycles then one idle: no watchdog error.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("wdt7.state", 32'(ctrl_state), 32'd2);
    checkOutput("wdt7.wdt_err", 32'(wdt_err), 32'd0);
    tick();
    checkOutput("wdt7_after.state", 32'(ctrl_state), 32'd1);
    checkOutput("wdt7_after.wdt_err", 32'(wdt_err), 32'd0);

    // Eight busy cycles: HALT at the 8th edge.
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("wdt8_%0d.wdt_err", i), 32'(wdt_err), 32'd0);
      tick();
    end
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("halt.state", 32'(ctrl_state), 32'd3);
    checkOutput("halt.wdt_err", 32'(wdt_err), 32'd1);
    checkCtrl("halt", V_IDLE);
    tick();
    tick();
    checkOutput("halt_hold.state", 32'(ctrl_state), 32'd3);
    checkOutput("halt_hold.wdt_err", 32'(wdt_err), 32'd1);

    // Reset during HALT returns to BOOT immediately.
    res = 1'b1;
    #1;
    checkOutput("rst_halt.state", 32'(ctrl_state), 32'd0);
    checkOutput("rst_halt.wdt_err", 32'(wdt_err), 32'd0);
    checkCtrl("rst_halt", V_BOOT);
    tick();
    res = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("reboot.state", 32'(ctrl_state), 32'd1);

`ifdef HAZARD_PERF_EN
    checkOutput("perf0.stall", stall_cnt, 32'd0);
    checkOutput("perf0.flush", flush_cnt, 32'd0);
    checkOutput("perf0.freeze", freeze_cnt, 32'd0);
    applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("perf.stall", stall_cnt, 32'd2);
    checkOutput("perf.flush", flush_cnt, 32'd1);
    checkOutput("perf.freeze", freeze_cnt, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencer for the 5-stage RISC-V core (IF/ID/EX/MEM/WB). Drives the PC write enable, per-stage register enables and per-stage bubble (flush) controls. It resolves, in fixed priority: data-memory freeze, taken-branch squash, and load-use stall. It also runs a post-reset boot drain and a data-memory watchdog that halts the core on a hung access.

## Interface
- BOOT_CYCLES, 4, cycles of pipeline drain after reset release; legal range is 1 or more.
- WDT_LIMIT, 64, consecutive `dmem_busy` cycles that trigger HALT; legal range is 2 or more.
- REG_AW, 5, register-address width.
- clk  in  1  core clock; all state updates on the rising edge.
- res  in  1  reset, asynchronous, active-high.
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in IF/ID.
- id_uses_rs1, id_uses_rs2  in  1  source actually read by that instruction.
- ex_rd  in  REG_AW  destination of the instruction in ID/EX.
- ex_mem_read  in  1  instruction in ID/EX is a load.
- mem_pcsrc  in  1  branch in EX/MEM resolved taken (PCSrc).
- dmem_busy  in  1  data memory not ready this cycle.
- pc_we  out  1  PC loads its next value.
- ifid_we, idex_we, exmem_we, memwb_we  out  1  stage register loads.
- ifid_flush, idex_flush, exmem_flush  out  1  stage loads a bubble (control fields zero) at the next edge.
- wdt_err  out  1  sticky watchdog error.
- ctrl_state  out  2  current state, for debug.

## Operation
- The states are BOOT, RUN, FREEZE and HALT. Outputs are combinational from the state and inputs; only the state and counters are registered.
- BOOT
  - Outputs: pc_we=0, all `*_we`=1, all flushes=1.
  - boot_cnt counts 0..BOOT_CYCLES-1, then the state moves to RUN.
  - dmem_busy and the hazard inputs are ignored.
- RUN and FREEZE evaluate the same priority chain each cycle:
  1. dmem_busy=1: all enables 0, all flushes 0; wdt_cnt increments; next state FREEZE.
  2. Else mem_pcsrc=1: pc_we=1 (PC takes the branch target); all `*_we`=1; ifid_flush, idex_flush and exmem_flush all 1. Any load-use hazard is ignored because the instruction is squashed.
  3. Else load-use: ex_mem_read=1 and ex_rd≠0 and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
     - pc_we=0, ifid_we=0, idex_flush=1.
     - idex_we, exmem_we and memwb_we are 1; other flushes are 0.
  4. Else: all enables 1, all flushes 0.
- Watchdog and FREEZE exit:
  - wdt_cnt clears whenever dmem_busy=0; any cycle with dmem_busy=0 returns the state to RUN.
  - If dmem_busy=1 while wdt_cnt==WDT_LIMIT-1, the next state is HALT and wdt_err is set to 1.
- HALT: all enables 0, all flushes 0, wdt_err=1. HALT is left only by res.
- Register x0 never creates a hazard.

## Timing
- Reset values:
  - state=BOOT, boot_cnt=0, wdt_cnt=0, wdt_err=0, performance counters 0.
  - Outputs therefore read as BOOT values while res=1: pc_we=0, all `*_we`=1, all flushes=1, wdt_err=0, ctrl_state=0.
- BOOT lasts exactly BOOT_CYCLES rising edges after res deasserts. RUN rules apply in the following cycle.
- Stall, flush and freeze decisions take effect in the same cycle the inputs are presented (zero latency). They act at the next edge.
- A load-use stall lasts exactly one cycle. At the next edge the load moves to EX/MEM and the compare clears.
- Watchdog: with dmem_busy held high from cycle k, HALT is entered at the edge ending cycle k+WDT_LIMIT-1. A single busy-free cycle before that point resets the count.
- res asserted mid-operation, including during HALT or FREEZE, returns the block immediately to BOOT with all counters cleared.

## Configuration
- HAZARD_PERF_EN defined:
  - Adds 32-bit outputs stall_cnt, flush_cnt and freeze_cnt.
  - Each counts cycles in which priority rule 3, rule 2 or rule 1 respectively was active.
  - The counters wrap at 2^32, are cleared by res, and do not count in BOOT or HALT.
- HAZARD_PERF_EN undefined: these ports and counters are absent, and the remaining behaviour is identical.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state encoding: BOOT=2'd0, RUN=2'd1, FREEZE=2'd2, HALT=2'd3;
  - the constant REG_ZERO;
  - the control-bit layout shared with the stage registers: controlWB {MemToReg,RegWrite}, controlMEM {Branch,MemRead,MemWrite}, controlEX {AluSrc,AluOp[1:0]}.
- One sub-module, hazard_detect, contains the purely combinational load-use compare (inputs id_rs*/id_uses_*/ex_rd/ex_mem_read, output load_use). The FSM and counters stay in pipe_ctrl.

## Test plan
- Reset, then release with BOOT_CYCLES=4: pc_we=0 and all flushes=1 for 4 cycles; ctrl_state=1 and pc_we=1 on the 5th.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → for one cycle pc_we=0, ifid_we=0, idex_flush=1; with ex_rd=0 instead, no stall.
- Branch plus load-use in the same cycle: mem_pcsrc=1 with the hazard above → pc_we=1 and all three flushes=1, no stall.
- Freeze: dmem_busy high 3 cycles with mem_pcsrc=1 → all enables 0 for 3 cycles, state=2; in the 4th cycle the flush applies.
- Watchdog with WDT_LIMIT=8: dmem_busy held 8 cycles → wdt_err=1 and state=3; dropping busy keeps HALT; res clears to BOOT. 7 busy cycles then 1 idle → no error.
- Under HAZARD_PERF_EN: 2 stalls, 1 branch and 3 freeze cycles → stall_cnt=2, flush_cnt=1, freeze_cnt=3.
